// File: rtl/bit_stream_serializer.sv
// Parallel-to-serial feeder for the pattern detector: shifts words out MSB-first, one bit per clock.
// Optional macro SER_PARITY_BIT_EN appends an even-parity bit after the LSB of each word.
module bit_stream_serializer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             dout,
    output logic             dout_valid,
    output logic             dout_last,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 2);
`ifdef SER_PARITY_BIT_EN
    localparam logic [CW-1:0] LAST = CW'(WIDTH);
`else
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
`endif

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] sr, sr_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic             dout_n, dv_n, dl_n;
    logic             accept;
`ifdef SER_PARITY_BIT_EN
    logic             par, par_n;
`endif

    // The last-bit cycle reopens the window so the next word follows with no gap.
    assign in_ready = ~reset & ((state == IDLE) | (cnt == LAST));
    assign accept   = in_valid & in_ready;

    always_comb begin
        state_n = state;
        sr_n    = sr;
        cnt_n   = cnt;
        dout_n  = 1'b0;
        dv_n    = 1'b0;
        dl_n    = 1'b0;
`ifdef SER_PARITY_BIT_EN
        par_n   = par;
`endif
        if (accept) begin
            state_n = SHIFT;
            sr_n    = {in_data[WIDTH-2:0], 1'b0};
            cnt_n   = '0;
            dout_n  = in_data[WIDTH-1];
            dv_n    = 1'b1;
`ifdef SER_PARITY_BIT_EN
            par_n   = ^in_data;
`endif
        end else if (state == SHIFT) begin
            if (cnt == LAST) begin
                state_n = IDLE;
                cnt_n   = '0;
            end else begin
                cnt_n  = cnt + CW'(1);
                dv_n   = 1'b1;
                dl_n   = ((cnt + CW'(1)) == LAST);
                sr_n   = sr << 1;
                dout_n = sr[WIDTH-1];
`ifdef SER_PARITY_BIT_EN
                if (cnt == LAST - CW'(1))
                    dout_n = par;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            sr         <= '0;
            cnt        <= '0;
            dout       <= 1'b0;
            dout_valid <= 1'b0;
            dout_last  <= 1'b0;
            busy       <= 1'b0;
`ifdef SER_PARITY_BIT_EN
            par        <= 1'b0;
`endif
        end else begin
            state      <= state_n;
            sr         <= sr_n;
            cnt        <= cnt_n;
            dout       <= dout_n;
            dout_valid <= dv_n;
            dout_last  <= dl_n;
            busy       <= (state_n == SHIFT);
`ifdef SER_PARITY_BIT_EN
            par        <= par_n;
`endif
        end
    end

endmodule

// File: tb/tb_bit_stream_serializer.sv
// Directed self-checking bench for bit_stream_serializer (WIDTH=8).
// Build with SER_PARITY_BIT_EN defined to exercise the parity cycle as well.
module tb_bit_stream_serializer;

    localparam int W = 8;
`ifdef SER_PARITY_BIT_EN
    localparam int NB = W + 1;
`else
    localparam int NB = W;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] in_data = '0;
    logic         in_valid = 1'b0;
    logic         in_ready, dout, dout_valid, dout_last, busy;
    int           errors = 0;
    int           checks = 0;

    bit_stream_serializer #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .dout(dout), .dout_valid(dout_valid),
        .dout_last(dout_last), .busy(busy)
    );

    always #5 clk = ~clk;

    // Expected wire bit i of a word: data MSB-first, then even parity when enabled.
    function automatic logic exp_bit(input logic [W-1:0] w, input int i);
        if (i < W) return w[W-1-i];
        return ^w;
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; in_valid = 1'b1; in_data = 8'hFF;
        step; step;
        checks++; if (dout !== 1'b0)       begin errors++; $display("FAIL rst_dout got=%b exp=0", dout); end
        checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL rst_dv got=%b exp=0", dout_valid); end
        checks++; if (dout_last !== 1'b0)  begin errors++; $display("FAIL rst_last got=%b exp=0", dout_last); end
        checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
        checks++; if (in_ready !== 1'b0)   begin errors++; $display("FAIL rst_ready got=%b exp=0", in_ready); end
        reset = 1'b0; in_valid = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1)   begin errors++; $display("FAIL idle_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_single(input logic [W-1:0] w);
        in_data = w; in_valid = 1'b1;
        step;
        in_valid = 1'b0;
        for (int i = 0; i < NB; i++) begin
            checks++; if (dout !== exp_bit(w, i)) begin errors++; $display("FAIL single_bit%0d got=%b exp=%b", i, dout, exp_bit(w, i)); end
            checks++; if (dout_valid !== 1'b1) begin errors++; $display("FAIL single_dv%0d got=%b exp=1", i, dout_valid); end
            checks++; if (dout_last !== (i == NB-1)) begin errors++; $display("FAIL single_last%0d got=%b exp=%b", i, dout_last, i == NB-1); end
            checks++; if (in_ready !== (i == NB-1)) begin errors++; $display("FAIL single_ready%0d got=%b exp=%b", i, in_ready, i == NB-1); end
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy%0d got=%b exp=1", i, busy); end
            step;
        end
        checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL single_end_dv got=%b exp=0", dout_valid); end
        checks++; if (dout !== 1'b0) begin errors++; $display("FAIL single_end_dout got=%b exp=0", dout); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_end_busy got=%b exp=0", busy); end
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] w;
        in_data = 8'hF0; in_valid = 1'b1;
        step;
        in_data = 8'h0A;
        for (int i = 0; i < 2*NB; i++) begin
            w = (i < NB) ? 8'hF0 : 8'h0A;
            checks++; if (dout !== exp_bit(w, i % NB)) begin errors++; $display("FAIL b2b_bit%0d got=%b exp=%b", i, dout, exp_bit(w, i % NB)); end
            checks++; if (dout_valid !== 1'b1) begin errors++; $display("FAIL b2b_dv%0d got=%b exp=1", i, dout_valid); end
            checks++; if (in_ready !== (i % NB == NB-1)) begin errors++; $display("FAIL b2b_ready%0d got=%b exp=%b", i, in_ready, i % NB == NB-1); end
            checks++; if (dout_last !== (i % NB == NB-1)) begin errors++; $display("FAIL b2b_last%0d got=%b exp=%b", i, dout_last, i % NB == NB-1); end
            if (i == 2*NB-1) in_valid = 1'b0;
            step;
        end
        checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL b2b_end_dv got=%b exp=0", dout_valid); end
    endtask

    task automatic test_gap;
        test_single(8'h3C);
        for (int i = 0; i < 4; i++) begin
            step;
            checks++; if (dout_valid !== 1'b0 || dout !== 1'b0) begin errors++; $display("FAIL gap_idle%0d got dv=%b d=%b exp 0/0", i, dout_valid, dout); end
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL gap_busy%0d got=%b exp=0", i, busy); end
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL gap_ready%0d got=%b exp=1", i, in_ready); end
        end
        test_single(8'h96);
    endtask

    task automatic test_reset_mid;
        in_data = 8'hFF; in_valid = 1'b1;
        step;
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (dout !== 1'b1) begin errors++; $display("FAIL rmid_bit%0d got=%b exp=1", i, dout); end
            step;
        end
        reset = 1'b1; in_valid = 1'b1; in_data = 8'h81;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rmid_ready_in_rst got=%b exp=0", in_ready); end
        step;
        checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL rmid_dv got=%b exp=0", dout_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got=%b exp=0", busy); end
        step;
        checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL rmid_nowin got=%b exp=0", dout_valid); end
        reset = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready_rel got=%b exp=1", in_ready); end
        step;
        in_valid = 1'b0;
        for (int i = 0; i < NB; i++) begin
            checks++; if (dout !== exp_bit(8'h81, i) || dout_valid !== 1'b1) begin errors++; $display("FAIL rmid_new%0d got d=%b dv=%b exp d=%b dv=1", i, dout, dout_valid, exp_bit(8'h81, i)); end
            step;
        end
        checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL rmid_end_dv got=%b exp=0", dout_valid); end
    endtask

    task automatic test_ignore;
        logic [W-1:0] w;
        w = 8'hC3;
        in_data = w; in_valid = 1'b1;
        step;
        for (int i = 0; i < NB; i++) begin
            checks++; if (dout !== exp_bit(w, i) || dout_valid !== 1'b1) begin errors++; $display("FAIL ign_bit%0d got d=%b dv=%b exp d=%b dv=1", i, dout, dout_valid, exp_bit(w, i)); end
            in_data  = ~in_data;
            in_valid = (i != NB-1);
            step;
        end
        checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL ign_end_dv got=%b exp=0", dout_valid); end
        in_valid = 1'b0;
    endtask

`ifdef SER_PARITY_BIT_EN
    task automatic test_parity;
        logic [W-1:0] words [2];
        logic         pexp  [2];
        words[0] = 8'h07; pexp[0] = 1'b1;
        words[1] = 8'h03; pexp[1] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            in_data = words[k]; in_valid = 1'b1;
            step;
            in_valid = 1'b0;
            for (int i = 0; i < W; i++) step;
            checks++; if (dout !== pexp[k] || dout_valid !== 1'b1) begin errors++; $display("FAIL par_bit w%0d got d=%b dv=%b exp d=%b dv=1", k, dout, dout_valid, pexp[k]); end
            checks++; if (dout_last !== 1'b1) begin errors++; $display("FAIL par_last w%0d got=%b exp=1", k, dout_last); end
            step;
            checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL par_end_dv w%0d got=%b exp=0", k, dout_valid); end
        end
    endtask
`endif

    initial begin
        test_reset;
        test_single(8'hA5);
        test_back_to_back;
        test_gap;
        test_reset_mid;
        test_ignore;
`ifdef SER_PARITY_BIT_EN
        test_parity;
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bit_stream_serializer.md
Name: bit_stream_serializer

Overview:
- Upstream feeder for the serial pattern-detector stage. Converts parallel words into the 1-bit-per-cycle stream that the detector consumes on its din input.
- Accepts words over a valid/ready handshake and shifts them out MSB-first, one bit per clock.
- Supports gapless back-to-back words, so that patterns spanning word boundaries remain detectable downstream.

Parameters:
- WIDTH, 8, data word width in bits; legal range WIDTH >= 2.

Ports:
- clk  input  1  single clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- in_data  input  WIDTH  parallel word to serialize
- in_valid  input  1  in_data is valid this cycle
- in_ready  output  1  block can accept a word this cycle
- dout  output  1  serial bit; drives detector din
- dout_valid  output  1  dout carries a real data (or parity) bit this cycle
- dout_last  output  1  dout is the final bit of the current word
- busy  output  1  a word is being shifted out (state SHIFT)

Behaviour:
- Reset is synchronous and active-high, sampled only on rising clk.
  - While reset is high: state=IDLE, shift register=0, bit counter=0.
  - Outputs while reset is high: dout=0, dout_valid=0, dout_last=0, busy=0, in_ready=0.
  - in_ready is gated by reset.
- State machine has two states, IDLE and SHIFT.
  - dout, dout_valid, dout_last and busy are registered.
  - in_ready is combinational from state and counter.
- IDLE:
  - in_ready=1, dout_valid=0, dout=0, dout_last=0.
  - Accept occurs when in_valid && in_ready at the edge: load the shift register with in_data, set counter=0, go to SHIFT.
- Latency: the first bit (in_data[WIDTH-1]) appears on dout with dout_valid=1 in the cycle after the accepting edge.
- SHIFT:
  - Each cycle presents the next bit MSB to LSB; the counter increments per bit.
  - The counter is $clog2(WIDTH+2) bits wide and never wraps within a word.
- Last-bit cycle (dout_last=1):
  - in_ready=1 in this cycle.
  - If in_valid=1, the new word loads and its MSB appears the very next cycle, with no idle gap and dout_valid held at 1.
  - Otherwise the block returns to IDLE, and dout_valid=0 in the next cycle.
- in_ready=0 in every other SHIFT cycle. in_data and in_valid are ignored while in_ready=0; upstream must hold its word.
- Word length on the wire is exactly WIDTH valid cycles (WIDTH+1 with the optional parity feature).
- Reset mid-word: the partial word is discarded with no flush. dout_valid=0 in the cycle after reset is sampled. The first accept after reset release starts from the MSB.
- Simultaneous reset and in_valid: reset wins and no word is accepted.
- dout is forced to 0 whenever dout_valid=0, so idle cycles feed zeros to the detector.

Optional Feature:
- Macro: SER_PARITY_BIT_EN
- Defined:
  - One extra cycle follows the LSB, carrying the even-parity bit (XOR-reduce of the accepted word), with dout_valid=1.
  - dout_last and the in_ready window move to the parity cycle, giving WIDTH+1 cycles per word.
  - The parity bit is computed and registered at accept time.
- Undefined: no parity cycle; dout_last is asserted on the LSB; no parity logic is synthesized.

Test Plan:
1. Reset release, then in_data=8'hA5 with in_valid for one cycle:
   - in_ready drops the next cycle.
   - dout = 1,0,1,0,0,1,0,1 over cycles 1..8 with dout_valid=1.
   - dout_last only on cycle 8; dout_valid=0 on cycle 9.
2. Back-to-back 8'hF0 then 8'h0A, in_valid held:
   - 16 contiguous valid bits: 11110000 00001010.
   - in_ready=1 only on the last-bit cycle of each word (and in IDLE).
   - The detector downstream pulses once, after bit 16.
3. in_valid low for 5 cycles between words:
   - dout_valid=0 and dout=0 for exactly those idle cycles.
   - busy=0 throughout; next word starts from its MSB.
4. Reset asserted after 3 bits of 8'hFF:
   - dout_valid=0 in the following cycle; in_ready=0 during reset, 1 after release.
   - A new 8'h81 then emits 10000001 cleanly.
5. in_valid asserted while in_ready=0, mid-word of 8'hC3 with in_data toggling:
   - Output stays 11000011, unaffected by the toggling in_data.
6. With SER_PARITY_BIT_EN, word 8'h07:
   - 9 valid bits 00000111 then parity bit 1.
   - dout_last on bit 9; word 8'h03 yields parity bit 0.
